// File: rtl/clk_sel_pkg.sv
// Shared constants for the clock-select sequencer: FSM state encodings and
// default timing parameters.
package clk_sel_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DWELL  = 2'd2;

   localparam int SETTLE_CYC_DEF    = 16;
   localparam int MIN_DWELL_CYC_DEF = 32;
   localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/clk_sel_cnt.sv
// Loadable saturating down-counter used to time the settle and dwell windows.
// Load has priority over decrement; the count holds at zero instead of wrapping.
module clk_sel_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-select sequencer in the clka domain: accepts switch requests, holds each
// new select through a settle window, then a dwell window, with a force-to-clka override.
module clk_sel_ctrl
   import clk_sel_pkg::*;
#(
   parameter int SETTLE_CYC    = SETTLE_CYC_DEF,
   parameter int MIN_DWELL_CYC = MIN_DWELL_CYC_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic       clka,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_sel,
   output logic       req_ready,
   input  logic       force_a,
   output logic       sel_clkb,
   output logic       busy,
   output logic       sw_done,
   output logic [1:0] state_dbg
);

   // Handshake: a request transfers on any clka edge where req_valid && req_ready;
   // req_valid/req_sel must stay stable until then, and requests are never queued.

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD  =
      (MIN_DWELL_CYC == 0) ? '0 : CNT_W'(MIN_DWELL_CYC - 1);
   localparam logic HAS_DWELL = (MIN_DWELL_CYC != 0);

   logic [1:0]       state_q;
   logic             sel_clkb_q;
   logic             busy_q;
   logic             sw_done_q;

   logic             accept;
   logic             accept_sw;
   logic             force_sw;
   logic             settle_end;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;

   assign req_ready = (state_q == ST_IDLE) & ~force_a & ~rst;

   always_comb begin
      accept       = req_valid & req_ready;
      accept_sw    = accept & (req_sel != sel_clkb_q);
      // Forcing only matters when clkb is selected; with clka already selected
      // any window in progress runs to completion.
      force_sw     = force_a & sel_clkb_q;
      settle_end   = (state_q == ST_SETTLE) & cnt_zero & ~force_sw;
      cnt_load     = force_sw | accept_sw | (settle_end & HAS_DWELL);
      cnt_load_val = (force_sw | accept_sw) ? SETTLE_LOAD : DWELL_LOAD;
      cnt_en       = (state_q != ST_IDLE);
   end

   clk_sel_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk_i      (clka),
      .rst_i      (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .en_i       (cnt_en),
      .cnt_o      (cnt_val),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clka) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_clkb_q <= 1'b0;
         busy_q     <= 1'b0;
         sw_done_q  <= 1'b0;
      end else begin
         sw_done_q <= 1'b0;
         if (force_sw) begin
            state_q    <= ST_SETTLE;
            sel_clkb_q <= 1'b0;
            busy_q     <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept_sw) begin
                     state_q    <= ST_SETTLE;
                     sel_clkb_q <= req_sel;
                     busy_q     <= 1'b1;
                  end
               end
               ST_SETTLE: begin
                  if (cnt_zero) begin
                     sw_done_q <= 1'b1;
                     if (HAS_DWELL) begin
                        state_q <= ST_DWELL;
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               ST_DWELL: begin
                  if (cnt_zero) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sel_clkb  = sel_clkb_q;
   assign busy      = busy_q;
   assign sw_done   = sw_done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl: default-parameter instance plus a
// SETTLE_CYC=1 / MIN_DWELL_CYC=0 instance for the no-dwell boundary.
module tb_clk_sel_ctrl;
   import clk_sel_pkg::*;

   logic       clka;
   logic       rst;
   logic       req_valid, req_sel, force_a;
   logic       req_ready, sel_clkb, busy, sw_done;
   logic [1:0] state_dbg;

   logic       z_req_valid, z_req_sel, z_force_a;
   logic       z_req_ready, z_sel_clkb, z_busy, z_sw_done;
   logic [1:0] z_state_dbg;

   int errors = 0;
   int checks = 0;

   clk_sel_ctrl dut (
      .clka(clka), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .force_a(force_a), .sel_clkb(sel_clkb),
      .busy(busy), .sw_done(sw_done), .state_dbg(state_dbg)
   );

   clk_sel_ctrl #(.SETTLE_CYC(1), .MIN_DWELL_CYC(0), .CNT_W(4)) dut_z (
      .clka(clka), .rst(rst), .req_valid(z_req_valid), .req_sel(z_req_sel),
      .req_ready(z_req_ready), .force_a(z_force_a), .sel_clkb(z_sel_clkb),
      .busy(z_busy), .sw_done(z_sw_done), .state_dbg(z_state_dbg)
   );

   // clock/reset
   initial begin
      clka = 1'b0;
      forever #5 clka = ~clka;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Outputs are sampled 1 ns after the active edge.
   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++; if (sel_clkb !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", sel_clkb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (sw_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", sw_done); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready); end
      checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
      checks++; if (z_req_ready !== 1'b1) begin errors++; $display("FAIL reset_z_ready_after: got %b want 1", z_req_ready); end
   endtask

   task automatic test_redundant();
      req_valid = 1'b1; req_sel = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL redundant_ready: got %b want 1", req_ready); end
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checks++; if (busy !== 1'b0 || sw_done !== 1'b0 || sel_clkb !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL redundant_c%0d: busy=%b done=%b sel=%b state=%0d want 0 0 0 0", c, busy, sw_done, sel_clkb, state_dbg);
         end
         step();
      end
   endtask

   task automatic test_switch_b();
      logic [1:0] exp_state;
      req_valid = 1'b1; req_sel = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL switch_ready_n: got %b want 1", req_ready); end
      step();
      req_valid = 1'b0;
      checks++; if (sel_clkb !== 1'b1 || busy !== 1'b1 || state_dbg !== ST_SETTLE || req_ready !== 1'b0) begin
         errors++; $display("FAIL switch_n1: sel=%b busy=%b state=%0d ready=%b want 1 1 1 0", sel_clkb, busy, state_dbg, req_ready);
      end
      for (int c = 2; c <= 49; c++) begin
         step();
         exp_state = (c <= 16) ? ST_SETTLE : (c <= 48) ? ST_DWELL : ST_IDLE;
         checks++; if (sw_done !== (c == 17) || busy !== (c <= 48) || req_ready !== (c == 49) ||
                       state_dbg !== exp_state || sel_clkb !== 1'b1) begin
            errors++; $display("FAIL switch_n%0d: done=%b busy=%b ready=%b state=%0d sel=%b want %b %b %b %0d 1",
                               c, sw_done, busy, req_ready, state_dbg, sel_clkb, c == 17, c <= 48, c == 49, exp_state);
         end
      end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_sel = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_m: got %b want 1", req_ready); end
      step();
      req_sel = 1'b1;
      #1;
      for (int c = 1; c <= 49; c++) begin
         checks++; if (req_ready !== (c == 49) || sel_clkb !== 1'b0 || sw_done !== (c == 17)) begin
            errors++; $display("FAIL b2b_m%0d: ready=%b sel=%b done=%b want %b 0 %b", c, req_ready, sel_clkb, sw_done, c == 49, c == 17);
         end
         if (c < 49) step();
      end
      step();
      req_valid = 1'b0;
      checks++; if (sel_clkb !== 1'b1 || busy !== 1'b1 || sw_done !== 1'b0) begin
         errors++; $display("FAIL b2b_m50: sel=%b busy=%b done=%b want 1 1 0", sel_clkb, busy, sw_done);
      end
      for (int c = 51; c <= 98; c++) begin
         step();
         checks++; if (sw_done !== (c == 66) || busy !== (c <= 97) || req_ready !== (c == 98) || sel_clkb !== 1'b1) begin
            errors++; $display("FAIL b2b_m%0d: done=%b busy=%b ready=%b sel=%b want %b %b %b 1",
                               c, sw_done, busy, req_ready, sel_clkb, c == 66, c <= 97, c == 98);
         end
      end
   endtask

   task automatic test_reset_mid_dwell();
      req_valid = 1'b1; req_sel = 1'b0;
      step();
      req_valid = 1'b0;
      for (int c = 2; c <= 30; c++) step();
      checks++; if (state_dbg !== ST_DWELL || busy !== 1'b1 || sel_clkb !== 1'b0) begin
         errors++; $display("FAIL rstdw_n30: state=%0d busy=%b sel=%b want %0d 1 0", state_dbg, busy, sel_clkb, ST_DWELL);
      end
      rst = 1'b1;
      step();
      checks++; if (sel_clkb !== 1'b0 || busy !== 1'b0 || sw_done !== 1'b0 || state_dbg !== ST_IDLE || req_ready !== 1'b0) begin
         errors++; $display("FAIL rstdw_n31: sel=%b busy=%b done=%b state=%0d ready=%b want 0 0 0 0 0",
                            sel_clkb, busy, sw_done, state_dbg, req_ready);
      end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstdw_ready: got %b want 1", req_ready); end
      for (int c = 0; c < 40; c++) begin
         step();
         checks++; if (sw_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstdw_late_%0d: done=%b busy=%b want 0 0", c, sw_done, busy);
         end
      end
   endtask

   task automatic test_force();
      logic [1:0] exp_state;
      force_a = 1'b1; req_valid = 1'b1; req_sel = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL force_idle_ready: got %b want 0", req_ready); end
      step();
      checks++; if (sel_clkb !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
         errors++; $display("FAIL force_no_accept: sel=%b busy=%b state=%0d want 0 0 0", sel_clkb, busy, state_dbg);
      end
      force_a = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL force_release_ready: got %b want 1", req_ready); end
      step();
      req_valid = 1'b0;
      checks++; if (sel_clkb !== 1'b1) begin errors++; $display("FAIL force_n1_sel: got %b want 1", sel_clkb); end
      for (int c = 2; c <= 5; c++) step();
      force_a = 1'b1;
      step();
      checks++; if (sel_clkb !== 1'b0 || busy !== 1'b1 || state_dbg !== ST_SETTLE) begin
         errors++; $display("FAIL force_n6: sel=%b busy=%b state=%0d want 0 1 1", sel_clkb, busy, state_dbg);
      end
      req_valid = 1'b1; req_sel = 1'b1;
      for (int c = 7; c <= 60; c++) begin
         step();
         exp_state = (c <= 21) ? ST_SETTLE : (c <= 53) ? ST_DWELL : ST_IDLE;
         checks++; if (sw_done !== (c == 22) || busy !== (c <= 53) || req_ready !== 1'b0 ||
                       sel_clkb !== 1'b0 || state_dbg !== exp_state) begin
            errors++; $display("FAIL force_n%0d: done=%b busy=%b ready=%b sel=%b state=%0d want %b %b 0 0 %0d",
                               c, sw_done, busy, req_ready, sel_clkb, state_dbg, c == 22, c <= 53, exp_state);
         end
      end
      force_a = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL force_pending_ready: got %b want 1", req_ready); end
      step();
      req_valid = 1'b0;
      checks++; if (sel_clkb !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL force_pending_accept: sel=%b busy=%b want 1 1", sel_clkb, busy);
      end
   endtask

   task automatic test_no_dwell();
      z_req_valid = 1'b1; z_req_sel = 1'b1;
      #1;
      checks++; if (z_req_ready !== 1'b1) begin errors++; $display("FAIL nodw_ready_n: got %b want 1", z_req_ready); end
      step();
      z_req_valid = 1'b0;
      checks++; if (z_sel_clkb !== 1'b1 || z_busy !== 1'b1 || z_state_dbg !== ST_SETTLE || z_sw_done !== 1'b0 || z_req_ready !== 1'b0) begin
         errors++; $display("FAIL nodw_n1: sel=%b busy=%b state=%0d done=%b ready=%b want 1 1 1 0 0",
                            z_sel_clkb, z_busy, z_state_dbg, z_sw_done, z_req_ready);
      end
      step();
      checks++; if (z_sw_done !== 1'b1 || z_busy !== 1'b0 || z_req_ready !== 1'b1 || z_state_dbg !== ST_IDLE) begin
         errors++; $display("FAIL nodw_n2: done=%b busy=%b ready=%b state=%0d want 1 0 1 0", z_sw_done, z_busy, z_req_ready, z_state_dbg);
      end
      step();
      checks++; if (z_sw_done !== 1'b0) begin errors++; $display("FAIL nodw_n3_done: got %b want 0", z_sw_done); end
      z_force_a = 1'b1;
      step();
      checks++; if (z_sel_clkb !== 1'b0 || z_busy !== 1'b1 || z_state_dbg !== ST_SETTLE) begin
         errors++; $display("FAIL nodw_force1: sel=%b busy=%b state=%0d want 0 1 1", z_sel_clkb, z_busy, z_state_dbg);
      end
      step();
      checks++; if (z_sw_done !== 1'b1 || z_busy !== 1'b0 || z_req_ready !== 1'b0 || z_sel_clkb !== 1'b0) begin
         errors++; $display("FAIL nodw_force2: done=%b busy=%b ready=%b sel=%b want 1 0 0 0", z_sw_done, z_busy, z_req_ready, z_sel_clkb);
      end
      z_force_a = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_sel = 1'b0; force_a = 1'b0;
      z_req_valid = 1'b0; z_req_sel = 1'b0; z_force_a = 1'b0;
      test_reset();
      test_redundant();
      test_switch_b();
      test_back_to_back();
      test_reset_mid_dwell();
      test_force();
      test_no_dwell();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
